pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) for the MIPS core.

---
 rtl/pipe_stage_reg.sv | 96 +++++++++
 tb/tb_pipe_stage_reg.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: DEPTH slices of {valid, ctrl, data} with hazard
// stall/flush control and saturating stall/flush event counters for perf debug.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 24,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_stage_reg: DEPTH must be in 1..4");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slice
            logic              r_valid;
            logic [CTRL_W-1:0] r_ctrl;
            logic [DATA_W-1:0] r_data;
            logic              w_valid_src;
            logic [CTRL_W-1:0] w_ctrl_src;
            logic [DATA_W-1:0] w_data_src;

            if (gi == 0) begin : g_head
                // Invalid entries enter as bubbles: control forced to NOP, data kept.
                assign w_valid_src = i_valid;
                assign w_ctrl_src  = i_valid ? i_ctrl : '0;
                assign w_data_src  = i_data;
            end else begin : g_body
                assign w_valid_src = g_slice[gi-1].r_valid;
                assign w_ctrl_src  = g_slice[gi-1].r_ctrl;
                assign w_data_src  = g_slice[gi-1].r_data;
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                    r_data  <= '0;
                end else if (i_flush) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                end else if (!i_stall) begin
                    r_valid <= w_valid_src;
                    r_ctrl  <= w_ctrl_src;
                    r_data  <= w_data_src;
                end
            end
        end
    endgenerate

    assign o_valid = g_slice[DEPTH-1].r_valid;
    assign o_ctrl  = g_slice[DEPTH-1].r_ctrl;
    assign o_data  = g_slice[DEPTH-1].r_data;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // A flush edge counts only as a flush even when stall is also asserted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (i_flush) begin
            if (r_flush_cnt != CNT_MAX) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end else if (i_stall) begin
            if (r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with DEPTH=2, CNT_W=4: reset, streaming,
// stall, flush-over-stall, bubble insertion and counter saturation.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 24;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              flush;
    logic              valid_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] data_o;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_stall    (stall),
        .i_flush    (flush),
        .i_valid    (valid_in),
        .i_ctrl     (ctrl_in),
        .i_data     (data_in),
        .o_valid    (valid_o),
        .o_ctrl     (ctrl_o),
        .o_data     (data_o),
        .o_stall_cnt(stall_cnt),
        .o_flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        valid_in = v;
        ctrl_in  = c;
        data_in  = d;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                           input logic [DATA_W-1:0] d);
        chk({tag, ".valid"}, 32'(valid_o), 32'(v));
        chk({tag, ".ctrl"},  32'(ctrl_o),  32'(c));
        chk({tag, ".data"},  data_o,       d);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, CTRL_W'($urandom), $urandom);
        #3;
        chk_out("reset_init", 1'b0, '0, '0);
        chk("reset_init.stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_init.flush_cnt", 32'(flush_cnt), 32'd0);
        step();
        step();
        #4 rst_n = 1'b1;

        // Stream: A presented at edge 0, visible after edge 1; B, C follow in order.
        drive(1'b1, 24'h00A5A5, 32'h1234_5678);
        step();
        chk("stream_e0.valid", 32'(valid_o), 32'd0);
        drive(1'b1, 24'h000111, 32'hAAAA_0001);
        step();
        chk_out("stream_A", 1'b1, 24'h00A5A5, 32'h1234_5678);
        drive(1'b1, 24'h000222, 32'hAAAA_0002);
        step();
        chk_out("stream_B", 1'b1, 24'h000111, 32'hAAAA_0001);

        // Stall 3 edges: B held on outputs, C held in slice0, D not captured.
        stall = 1'b1;
        drive(1'b1, 24'h000333, 32'hAAAA_0003);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("stall_hold%0d", i), 1'b1, 24'h000111, 32'hAAAA_0001);
        end
        chk("stall.stall_cnt", 32'(stall_cnt), 32'd3);
        stall = 1'b0;
        step();
        chk_out("stall_release_C", 1'b1, 24'h000222, 32'hAAAA_0002);
        chk("stall_release.stall_cnt", 32'(stall_cnt), 32'd3);

        // Flush with stall: bubble on outputs, data kept, only FlushCnt moves.
        stall = 1'b1;
        flush = 1'b1;
        drive(1'b1, 24'h000999, 32'hBBBB_0009);
        step();
        chk_out("flush_stall", 1'b0, '0, 32'hAAAA_0002);
        chk("flush_stall.flush_cnt", 32'(flush_cnt), 32'd1);
        chk("flush_stall.stall_cnt", 32'(stall_cnt), 32'd3);
        stall = 1'b0;
        flush = 1'b0;

        // Flushed slice0 still carries D's data; then a bubble input goes through.
        drive(1'b0, 24'hFFFFFF, 32'hDEAD_BEEF);
        step();
        chk_out("post_flush", 1'b0, '0, 32'hAAAA_0003);
        drive(1'b1, 24'h000444, 32'h0000_0005);
        step();
        chk_out("bubble", 1'b0, '0, 32'hDEAD_BEEF);
        drive(1'b1, 24'h000555, 32'h0000_0006);
        step();
        chk_out("after_bubble", 1'b1, 24'h000444, 32'h0000_0005);

        // Asynchronous reset mid-cycle while stalling with state in flight.
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, '0, '0);
        chk("async_reset.stall_cnt", 32'(stall_cnt), 32'd0);
        chk("async_reset.flush_cnt", 32'(flush_cnt), 32'd0);
        #1 rst_n = 1'b1;

        // Saturation: StallCnt reaches 4'hF after 15 edges and stays there.
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) chk("sat.stall_cnt14", 32'(stall_cnt), 32'hE);
            if (i == 15) chk("sat.stall_cnt15", 32'(stall_cnt), 32'hF);
        end
        chk("sat.stall_cnt20", 32'(stall_cnt), 32'hF);
        chk("sat.flush_cnt", 32'(flush_cnt), 32'd0);
        stall = 1'b0;
        flush = 1'b1;
        for (int i = 1; i <= 17; i++) step();
        chk("sat.flush_cnt17", 32'(flush_cnt), 32'hF);
        chk("sat.stall_cnt_kept", 32'(stall_cnt), 32'hF);
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
